// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared state encodings and the per-cycle control bundle for the hazard sequencer.
package pipeline_hazard_ctrl_pkg;

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_EXWAIT   = 2'd1;
  localparam logic [1:0] ST_FLUSHING = 2'd2;

  typedef struct packed {
    logic if_en;
    logic id_en;
    logic ex_en;
    logic mem_en;
    logic bubble_id;
    logic bubble_ex;
    logic flush;
    logic exstage_stalled;
  } ctrl_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear (clear beats increment).
module pipeline_hazard_ctrl_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  // count up, stick at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               cnt <= '0;
    else if (clr)             cnt <= '0;
    else if (inc && !(&cnt))  cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage core: turns hazard sources into
// per-stage advance enables, bubble inserts and the scoreboard issue strobe.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int EX_TIMEOUT   = 64,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             operands_ready,
  input  logic             ins_cache_ready,
  input  logic             data_cache_ready,
  input  logic             flush_req,
  input  logic             ex_multi_start,
  input  logic             ex_done,
  input  logic             cnt_clr,
  output logic             if_en,
  output logic             id_en,
  output logic             ex_en,
  output logic             mem_en,
  output logic             bubble_id,
  output logic             bubble_ex,
  output logic             flush,
  output logic             stall_enable_fb,
  output logic             exstage_stalled,
  output logic             ex_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int FW = $clog2(FLUSH_CYCLES) + 1;
  localparam int TW = $clog2(EX_TIMEOUT) + 1;

  logic [1:0]    state;
  logic          flush_pend;
  logic [FW-1:0] fcnt;
  logic [TW-1:0] tcnt;
  logic          freeze;
  logic          do_flush;
  ctrl_t         c;

  assign freeze   = !data_cache_ready;
  // a redirect seen during a D-cache freeze is replayed on the first live cycle
  assign do_flush = flush_req | flush_pend;

  // sequencer state; everything holds while the D-cache freezes the pipe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_RUN;
      flush_pend <= 1'b0;
      fcnt       <= '0;
      tcnt       <= '0;
      ex_err     <= 1'b0;
    end else if (freeze) begin
      if (flush_req) flush_pend <= 1'b1;
    end else if (do_flush) begin
      flush_pend <= 1'b0;
      tcnt       <= '0;
      if (FLUSH_CYCLES == 1) begin
        state <= ST_RUN;
      end else begin
        state <= ST_FLUSHING;
        fcnt  <= FW'(FLUSH_CYCLES - 1);
      end
    end else begin
      case (state)
        ST_FLUSHING: begin
          fcnt <= fcnt - 1'b1;
          if (fcnt <= FW'(1)) state <= ST_RUN;
        end
        ST_EXWAIT: begin
          if (ex_done) begin
            state <= ST_RUN;
            tcnt  <= '0;
          end else if (tcnt == TW'(EX_TIMEOUT - 1)) begin
            ex_err <= 1'b1;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: begin
          if (ex_multi_start) begin
            state <= ST_EXWAIT;
            tcnt  <= '0;
          end
        end
      endcase
    end
  end

  // per-cycle control decode: reset > freeze > flush > EXWAIT > I-miss > operand hazard > run
  always_comb begin
    c = '0;
    if (!rst_n) begin
      c.bubble_id = 1'b1;
      c.bubble_ex = 1'b1;
      c.flush     = 1'b1;
    end else if (freeze) begin
      c.exstage_stalled = (state == ST_EXWAIT);
    end else if (do_flush) begin
      c.if_en     = 1'b1;
      c.id_en     = 1'b1;
      c.ex_en     = 1'b1;
      c.mem_en    = 1'b1;
      c.bubble_id = 1'b1;
      c.bubble_ex = 1'b1;
      c.flush     = 1'b1;
    end else begin
      case (state)
        ST_FLUSHING: begin
          c.if_en     = ins_cache_ready;
          c.id_en     = ins_cache_ready;
          c.ex_en     = 1'b1;
          c.mem_en    = 1'b1;
          c.bubble_id = 1'b1;
        end
        ST_EXWAIT: begin
          // ID->EX never takes a fresh instruction here; the op's successor is already there
          c.mem_en    = 1'b1;
          c.bubble_id = 1'b1;
          if (ex_done) begin
            c.ex_en = 1'b1;
          end else begin
            c.bubble_ex       = 1'b1;
            c.exstage_stalled = 1'b1;
          end
        end
        default: begin
          c.ex_en  = 1'b1;
          c.mem_en = 1'b1;
          if (!ins_cache_ready) begin
            c.bubble_id = !operands_ready;
          end else if (!operands_ready) begin
            c.bubble_id = 1'b1;
          end else begin
            c.if_en = 1'b1;
            c.id_en = 1'b1;
          end
        end
      endcase
    end
  end

  assign if_en           = c.if_en;
  assign id_en           = c.id_en;
  assign ex_en           = c.ex_en;
  assign mem_en          = c.mem_en;
  assign bubble_id       = c.bubble_id;
  assign bubble_ex       = c.bubble_ex;
  assign flush           = c.flush;
  assign exstage_stalled = c.exstage_stalled;
  assign stall_enable_fb = rst_n & !freeze & c.ex_en & !c.bubble_id & !c.flush;

  pipeline_hazard_ctrl_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (!stall_enable_fb),
    .clr   (cnt_clr),
    .cnt   (stall_cnt)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench: default instance (FLUSH_CYCLES=2, EX_TIMEOUT=64) plus a
// short-timeout, 3-bit-counter instance sharing the same stimulus.
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  logic rst_n, operands_ready, ins_cache_ready, data_cache_ready;
  logic flush_req, ex_multi_start, ex_done, cnt_clr;

  logic if_en, id_en, ex_en, mem_en, bubble_id, bubble_ex, flush, fb, stalled, ex_err;
  logic [31:0] stall_cnt;
  logic t_if_en, t_id_en, t_ex_en, t_mem_en, t_bubble_id, t_bubble_ex, t_flush, t_fb, t_stalled, t_ex_err;
  logic [2:0] t_stall_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.FLUSH_CYCLES(2), .EX_TIMEOUT(64), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .operands_ready(operands_ready), .ins_cache_ready(ins_cache_ready),
    .data_cache_ready(data_cache_ready), .flush_req(flush_req), .ex_multi_start(ex_multi_start),
    .ex_done(ex_done), .cnt_clr(cnt_clr), .if_en(if_en), .id_en(id_en), .ex_en(ex_en),
    .mem_en(mem_en), .bubble_id(bubble_id), .bubble_ex(bubble_ex), .flush(flush),
    .stall_enable_fb(fb), .exstage_stalled(stalled), .ex_err(ex_err), .stall_cnt(stall_cnt)
  );

  pipeline_hazard_ctrl #(.FLUSH_CYCLES(2), .EX_TIMEOUT(4), .CNT_W(3)) dut_t (
    .clk(clk), .rst_n(rst_n), .operands_ready(operands_ready), .ins_cache_ready(ins_cache_ready),
    .data_cache_ready(data_cache_ready), .flush_req(flush_req), .ex_multi_start(ex_multi_start),
    .ex_done(ex_done), .cnt_clr(cnt_clr), .if_en(t_if_en), .id_en(t_id_en), .ex_en(t_ex_en),
    .mem_en(t_mem_en), .bubble_id(t_bubble_id), .bubble_ex(t_bubble_ex), .flush(t_flush),
    .stall_enable_fb(t_fb), .exstage_stalled(t_stalled), .ex_err(t_ex_err), .stall_cnt(t_stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance one clock; inputs change 1ns after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // enables packed as {if,id,ex,mem}
  function automatic logic [3:0] ens();
    return {if_en, id_en, ex_en, mem_en};
  endfunction

  initial begin
    rst_n = 1'b0; operands_ready = 1'b1; ins_cache_ready = 1'b1; data_cache_ready = 1'b1;
    flush_req = 1'b0; ex_multi_start = 1'b0; ex_done = 1'b0; cnt_clr = 1'b0;
    #2;
    chk("rst_en",     32'(ens()), 32'h0);
    chk("rst_bub",    32'({bubble_id, bubble_ex}), 32'h3);
    chk("rst_flush",  32'(flush), 32'h1);
    chk("rst_fb",     32'(fb), 32'h0);
    chk("rst_cnt",    stall_cnt, 32'd0);
    chk("rst_err",    32'(ex_err), 32'h0);
    tick(); tick();
    rst_n = 1'b1; #1;
    chk("run_en",     32'(ens()), 32'hF);
    chk("run_flush",  32'(flush), 32'h0);
    chk("run_fb",     32'(fb), 32'h1);
    tick();
    chk("run_cnt",    stall_cnt, 32'd0);

    // operand hazard for three cycles
    operands_ready = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      chk("haz_ifid", 32'({if_en, id_en}), 32'h0);
      chk("haz_bub",  32'(bubble_id), 32'h1);
      chk("haz_fb",   32'(fb), 32'h0);
      tick();
    end
    operands_ready = 1'b1; #1;
    chk("haz_cnt",    stall_cnt, 32'd3);
    chk("haz_resume", 32'(fb), 32'h1);

    // I-cache miss with ready operands still issues
    ins_cache_ready = 1'b0; #1;
    chk("imiss_en",   32'(ens()), 32'h3);
    chk("imiss_fb",   32'(fb), 32'h1);
    tick();
    ins_cache_ready = 1'b1;

    // counter clear
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0; #1;
    chk("clr_cnt",    stall_cnt, 32'd0);

    // single redirect
    flush_req = 1'b1; #1;
    chk("fl_flush",   32'(flush), 32'h1);
    chk("fl_en",      32'(ens()), 32'hF);
    chk("fl_bub",     32'({bubble_id, bubble_ex}), 32'h3);
    chk("fl_fb",      32'(fb), 32'h0);
    tick();
    flush_req = 1'b0; #1;
    chk("fl2_flush",  32'(flush), 32'h0);
    chk("fl2_bub",    32'(bubble_id), 32'h1);
    chk("fl2_ex",     32'({ex_en, mem_en}), 32'h3);
    tick();
    chk("fl3_bub",    32'(bubble_id), 32'h0);
    chk("fl3_fb",     32'(fb), 32'h1);

    // freeze for four cycles with a redirect in the second
    data_cache_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      flush_req = (i == 1); #1;
      chk("frz_en",    32'(ens()), 32'h0);
      chk("frz_flush", 32'(flush), 32'h0);
      tick();
    end
    flush_req = 1'b0; data_cache_ready = 1'b1; #1;
    chk("frz_pend",   32'(flush), 32'h1);
    tick();
    chk("frz_fling",  32'({flush, bubble_id}), 32'h1);
    tick();
    chk("frz_run",    32'(fb), 32'h1);
    chk("frz_cnt",    stall_cnt, 32'd8);
    chk("sat_cnt",    32'(t_stall_cnt), 32'd7);

    // multi-cycle op, done after five wait cycles
    ex_multi_start = 1'b1; #1;
    chk("ms_ex",      32'(ex_en), 32'h1);
    chk("ms_fb",      32'(fb), 32'h1);
    tick();
    ex_multi_start = 1'b0; #1;
    for (int i = 0; i < 5; i++) begin
      chk("ew_stall",  32'(stalled), 32'h1);
      chk("ew_en",     32'(ens()), 32'h1);
      chk("ew_bubex",  32'(bubble_ex), 32'h1);
      if (i == 3) chk("to_err_pre", 32'(t_ex_err), 32'h0);
      if (i == 4) chk("to_err",     32'(t_ex_err), 32'h1);
      tick();
    end
    ex_done = 1'b1; #1;
    chk("dn_ex",      32'(ex_en), 32'h1);
    chk("dn_stall",   32'(stalled), 32'h0);
    chk("dn_bubex",   32'(bubble_ex), 32'h0);
    tick();
    ex_done = 1'b0; #1;
    chk("dn_run",     32'(fb), 32'h1);
    chk("dn_err",     32'(ex_err), 32'h0);
    chk("to_sticky",  32'(t_ex_err), 32'h1);

    // start and redirect together: redirect wins
    ex_multi_start = 1'b1; flush_req = 1'b1; #1;
    chk("msf_flush",  32'(flush), 32'h1);
    tick();
    ex_multi_start = 1'b0; flush_req = 1'b0; #1;
    chk("msf_nowait", 32'(stalled), 32'h0);
    tick();
    chk("msf_run",    32'(fb), 32'h1);

    // EXWAIT holds through a freeze even with EX_DONE up, then reset mid-wait
    ex_multi_start = 1'b1;
    tick();
    ex_multi_start = 1'b0; data_cache_ready = 1'b0; ex_done = 1'b1; #1;
    chk("fzw_ex",     32'(ex_en), 32'h0);
    tick();
    data_cache_ready = 1'b1; ex_done = 1'b0; #1;
    chk("fzw_hold",   32'(stalled), 32'h1);
    #2; rst_n = 1'b0; #1;
    chk("mr_en",      32'(ens()), 32'h0);
    chk("mr_flush",   32'(flush), 32'h1);
    chk("mr_fb",      32'(fb), 32'h0);
    chk("mr_err",     32'(t_ex_err), 32'h0);
    tick();
    rst_n = 1'b1; #1;
    chk("mr_run",     32'({stalled, fb}), 32'h1);
    tick();
    chk("mr_state",   32'(stalled), 32'h0);
    chk("mr_cnt",     stall_cnt, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
